spi_reg_writer: RTL

SPI_REG_WRITER -- requirements
Module: spi_reg_writer

---
 rtl/spi_reg_writer.sv | 115 +++++++++++
 1 files changed

// File: rtl/spi_reg_writer.sv
// rtl/spi_reg_writer.sv - 16-bit SPI mode-0 register write/read frame generator
module spi_reg_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Last phase count value; every phase (setup, high, low, gap) lasts CLK_DIV cycles.
  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic        phase_end;

  assign phase_end = (phase_q == PHASE_LAST);

  // State, phase/bit counters and frame shift register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 8'd0;
      bit_q   <= 5'd0;
      shreg_q <= 16'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic and Moore outputs; copi always presents the shift register MSB while selected.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 8'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    busy    = 1'b1;
    done    = 1'b0;
    ncs     = 1'b0;
    sclk    = 1'b0;
    copi    = shreg_q[15];
    case (state_q)
      IDLE: begin
        busy    = 1'b0;
        ncs     = 1'b1;
        copi    = 1'b0;
        phase_d = 8'd0;
        if (start) begin
          state_d = SETUP;
          shreg_d = {rw, addr, wdata};
          bit_d   = 5'd0;
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_d = HIGH;
          phase_d = 8'd0;
        end
      end
      HIGH: begin
        sclk = 1'b1;
        if (phase_end) begin
          state_d = LOW;
          phase_d = 8'd0;
          bit_d   = bit_q + 5'd1;
          // The last bit stays on copi through the final low phase (ncs hold).
          if (bit_q != 5'd15) begin
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          phase_d = 8'd0;
          state_d = (bit_q == 5'd16) ? GAP : HIGH;
        end
      end
      GAP: begin
        ncs  = 1'b1;
        copi = 1'b0;
        done = (phase_q == 8'd0);
        if (phase_end) begin
          state_d = IDLE;
          phase_d = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 8'd0;
      end
    endcase
  end

endmodule
